// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller placed right after the EX/M latch.
// Runs one data-cache transaction at a time and stalls the pipeline until dhit.
// Returns load data and keeps the LL/SC link register, which snoops invalidate.
// Build option: define ATOMIC_LLSC_EN to enable LL/SC link tracking. In the
// default build LL acts as a plain load and SC as a plain store reporting 1.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic              req_atomic,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_store,
  input  logic              req_halt,
  input  logic              flush,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [DATA_W-1:0] load_data,
  output logic              halt_out
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              op_atomic, op_atomic_n;
  logic              dmemREN_n, dmemWEN_n, mem_done_n, halt_out_n;
  logic [ADDR_W-1:0] dmemaddr_n;
  logic [DATA_W-1:0] dmemstore_n, load_data_n;
  logic              sc_fail;

`ifdef ATOMIC_LLSC_EN
  logic              link_valid, link_valid_n;
  logic [WORD_W-1:0] link_addr, link_addr_n;
  logic [WORD_W-1:0] snoop_word, cur_word;
  logic              snoop_hit_link, ll_commit, sc_commit;
  logic [1:0]        unused_snoop_lsb;

  assign snoop_word       = snoop_addr[ADDR_W-1:2];
  assign cur_word         = dmemaddr[ADDR_W-1:2];
  assign unused_snoop_lsb = snoop_addr[1:0];
  assign snoop_hit_link   = snoop_valid && (snoop_word == link_addr);
  // An SC fails on a stale link; a snoop hitting the link this same cycle wins.
  assign sc_fail   = !req_ren && req_atomic &&
                     !(link_valid && (link_addr == req_addr[ADDR_W-1:2]) && !snoop_hit_link);
  assign ll_commit = (state == BUSY) && dhit && dmemREN && op_atomic;
  assign sc_commit = (state == BUSY) && dhit && dmemWEN && op_atomic;

  // Link register next state: snoop clears, LL sets (a same-word snoop still wins), SC clears.
  always_comb begin
    link_valid_n = link_valid;
    link_addr_n  = link_addr;
    if (snoop_hit_link) link_valid_n = 1'b0;
    if (ll_commit) begin
      link_addr_n  = cur_word;
      link_valid_n = !(snoop_valid && (snoop_word == cur_word));
    end
    if (sc_commit) link_valid_n = 1'b0;
  end

  // Link register state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      link_valid <= link_valid_n;
      link_addr  <= link_addr_n;
    end
  end
`else
  logic unused_snoop;

  assign unused_snoop = ^{snoop_valid, snoop_addr};
  assign sc_fail      = 1'b0;
`endif

  // Stall while a request waits to issue or a cache transaction is outstanding.
  assign mem_stall = ((state == IDLE) && req_valid && (req_ren || req_wen) && !flush && !halt_out)
                   || (state == BUSY);

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_n     = state;
    op_atomic_n = op_atomic;
    dmemREN_n   = dmemREN;
    dmemWEN_n   = dmemWEN;
    dmemaddr_n  = dmemaddr;
    dmemstore_n = dmemstore;
    load_data_n = load_data;
    halt_out_n  = halt_out;
    mem_done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (req_valid && req_halt) begin
          state_n    = HALTED;
          halt_out_n = 1'b1;
        end else if (req_valid && (req_ren || req_wen)) begin
          if (sc_fail) begin
            load_data_n = '0;
            mem_done_n  = 1'b1;
            state_n     = DONE;
          end else begin
            dmemaddr_n  = req_addr;
            dmemstore_n = req_store;
            op_atomic_n = req_atomic;
            dmemREN_n   = req_ren;
            dmemWEN_n   = !req_ren;
            state_n     = BUSY;
          end
        end
      end
      BUSY: begin
        if (dhit) begin
          dmemREN_n  = 1'b0;
          dmemWEN_n  = 1'b0;
          mem_done_n = 1'b1;
          state_n    = DONE;
          if (dmemREN) begin
            load_data_n = dmemload;
          end else if (op_atomic) begin
            load_data_n = DATA_W'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      HALTED:  state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op_atomic <= 1'b0;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      load_data <= '0;
      mem_done  <= 1'b0;
      halt_out  <= 1'b0;
    end else begin
      state     <= state_n;
      op_atomic <= op_atomic_n;
      dmemREN   <= dmemREN_n;
      dmemWEN   <= dmemWEN_n;
      dmemaddr  <= dmemaddr_n;
      dmemstore <= dmemstore_n;
      load_data <= load_data_n;
      mem_done  <= mem_done_n;
      halt_out  <= halt_out_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written corner sequences,
// and random transactions checked against a transaction-level model.
module tb_mem_access_ctrl;

`ifdef ATOMIC_LLSC_EN
  localparam bit ATOMIC = 1'b1;
`else
  localparam bit ATOMIC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ren, req_wen, req_atomic, req_halt, flush;
  logic [31:0] req_addr, req_store;
  logic        dmemREN, dmemWEN, dhit, snoop_valid;
  logic [31:0] dmemaddr, dmemstore, dmemload, snoop_addr, load_data;
  logic        mem_stall, mem_done, halt_out;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen), .req_atomic(req_atomic),
    .req_addr(req_addr), .req_store(req_store), .req_halt(req_halt), .flush(flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .mem_stall(mem_stall), .mem_done(mem_done), .load_data(load_data), .halt_out(halt_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        done;
    int          nren, nwen, lat;
    logic [31:0] ld, addr, store;
    logic        stall_bad, unstable, drop_bad;
  } res_t;

  typedef struct {
    logic        ren, wen, atm;
    logic [31:0] addr, store;
    int          k;
    logic [31:0] ldv;
    int          snp_at;
    logic [31:0] snp_a;
    int          e_nren, e_nwen, e_lat;
    logic [31:0] e_ld;
  } vec_t;

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // Drive one request and act as the cache: dhit on the k-th issued cycle.
  // snp_at selects the cycle (0 = request cycle) carrying a snoop, -1 for none.
  task automatic run_txn(input logic ren, input logic wen, input logic atm,
                         input logic [31:0] addr, input logic [31:0] store, input int k,
                         input logic [31:0] ldv, input int snp_at, input logic [31:0] snp_a,
                         output res_t r);
    res_t t;
    t.done = 1'b0; t.nren = 0; t.nwen = 0; t.lat = -1;
    t.ld = '0; t.addr = '0; t.store = '0;
    t.stall_bad = 1'b0; t.unstable = 1'b0; t.drop_bad = 1'b0;
    req_valid = 1'b1; req_ren = ren; req_wen = wen; req_atomic = atm;
    req_addr = addr; req_store = store; req_halt = 1'b0;
    for (int c = 0; c < 60 && !t.done; c++) begin
      snoop_valid = (c == snp_at);
      snoop_addr  = snp_a;
      @(negedge CLK);
      if (mem_done) begin
        t.done = 1'b1; t.lat = c; t.ld = load_data;
        if (mem_stall !== 1'b0) t.stall_bad = 1'b1;
        if (dmemREN || dmemWEN) t.drop_bad = 1'b1;
      end else begin
        if (mem_stall !== 1'b1) t.stall_bad = 1'b1;
        if (dmemREN || dmemWEN) begin
          if (t.nren + t.nwen == 0) begin
            t.addr = dmemaddr; t.store = dmemstore;
          end else if (dmemaddr !== t.addr || dmemstore !== t.store) begin
            t.unstable = 1'b1;
          end
          t.nren += int'(dmemREN);
          t.nwen += int'(dmemWEN);
          if (t.nren + t.nwen == k) begin
            dhit = 1'b1; dmemload = ldv;
          end
        end
      end
      @(posedge CLK); #1;
      dhit = 1'b0; dmemload = '0;
    end
    req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0; req_atomic = 1'b0; snoop_valid = 1'b0;
    r = t;
  endtask

  task automatic check_txn(input string tag, input res_t r, input int e_nren, input int e_nwen,
                           input int e_lat, input logic [31:0] e_ld, input logic [31:0] e_addr,
                           input logic [31:0] e_store);
    chk(tag, "done_seen", 32'(r.done), 32'd1);
    chk(tag, "ren_cycles", 32'(r.nren), 32'(e_nren));
    chk(tag, "wen_cycles", 32'(r.nwen), 32'(e_nwen));
    chk(tag, "latency", 32'(r.lat), 32'(e_lat));
    chk(tag, "load_data", r.ld, e_ld);
    chk(tag, "stall_shape", 32'(r.stall_bad), 32'd0);
    chk(tag, "bus_stable", 32'(r.unstable), 32'd0);
    chk(tag, "req_dropped", 32'(r.drop_bad), 32'd0);
    if (e_nren + e_nwen > 0) begin
      chk(tag, "dmemaddr", r.addr, e_addr);
      chk(tag, "dmemstore", r.store, e_store);
    end
  endtask

  function automatic vec_t mk(input logic ren, input logic wen, input logic atm,
                              input logic [31:0] addr, input logic [31:0] store, input int k,
                              input logic [31:0] ldv, input int snp_at, input logic [31:0] snp_a,
                              input bit iss, input logic [31:0] e_ld);
    vec_t v;
    v.ren = ren; v.wen = wen; v.atm = atm; v.addr = addr; v.store = store; v.k = k;
    v.ldv = ldv; v.snp_at = snp_at; v.snp_a = snp_a; v.e_ld = e_ld;
    v.e_nren = (iss && ren) ? k : 0;
    v.e_nwen = (iss && !ren) ? k : 0;
    v.e_lat  = iss ? k + 1 : 1;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    res_t        r;
    bit          m_lv;
    logic [29:0] m_lw;
    logic [31:0] m_ld;
    logic [31:0] sc_res;

    RST = 1'b1; req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0; req_atomic = 1'b0;
    req_addr = '0; req_store = '0; req_halt = 1'b0; flush = 1'b0;
    dhit = 1'b0; dmemload = '0; snoop_valid = 1'b0; snoop_addr = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state.
    @(negedge CLK);
    chk("reset", "dmemREN", 32'(dmemREN), 32'd0);
    chk("reset", "dmemWEN", 32'(dmemWEN), 32'd0);
    chk("reset", "dmemaddr", dmemaddr, 32'd0);
    chk("reset", "dmemstore", dmemstore, 32'd0);
    chk("reset", "mem_done", 32'(mem_done), 32'd0);
    chk("reset", "load_data", load_data, 32'd0);
    chk("reset", "halt_out", 32'(halt_out), 32'd0);
    chk("reset", "mem_stall", 32'(mem_stall), 32'd0);
    @(posedge CLK); #1;

    // Directed vectors; SC outcomes depend on whether link tracking is built in.
    sc_res = ATOMIC ? 32'd0 : 32'd1;
    tbl.push_back(mk(1, 0, 0, 32'h100, 32'h0,    2, 32'hDEADBEEF, -1, 32'h0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 0, 32'h40,  32'h1234, 1, 32'h0,        -1, 32'h0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 1, 32'h80,  32'h0,    1, 32'h55,       -1, 32'h0, 1, 32'h55));
    tbl.push_back(mk(0, 1, 1, 32'h80,  32'h7,    1, 32'h0,        -1, 32'h0, 1, 32'h1));
    tbl.push_back(mk(0, 1, 1, 32'h80,  32'h7,    1, 32'h0,        -1, 32'h0, !ATOMIC, sc_res));
    tbl.push_back(mk(1, 1, 0, 32'h200, 32'hFF,   1, 32'hA5A5,     -1, 32'h0, 1, 32'hA5A5));
    tbl.push_back(mk(1, 0, 1, 32'h80,  32'h0,    1, 32'h9,        -1, 32'h0, 1, 32'h9));
    tbl.push_back(mk(1, 0, 0, 32'h300, 32'h0,    1, 32'h11,        0, 32'h82, 1, 32'h11));
    tbl.push_back(mk(0, 1, 1, 32'h80,  32'h3,    1, 32'h0,        -1, 32'h0, !ATOMIC, sc_res));
    tbl.push_back(mk(1, 0, 1, 32'h84,  32'h0,    2, 32'h22,        2, 32'h86, 1, 32'h22));
    tbl.push_back(mk(0, 1, 1, 32'h84,  32'h4,    1, 32'h0,        -1, 32'h0, !ATOMIC, sc_res));
    tbl.push_back(mk(1, 0, 1, 32'hC0,  32'h0,    1, 32'h33,       -1, 32'h0, 1, 32'h33));
    tbl.push_back(mk(0, 1, 1, 32'hC0,  32'h5,    1, 32'h0,         0, 32'hC1, !ATOMIC, sc_res));
    tbl.push_back(mk(1, 0, 1, 32'hC0,  32'h0,    1, 32'h44,       -1, 32'h0, 1, 32'h44));
    tbl.push_back(mk(0, 1, 0, 32'hC0,  32'h5,    1, 32'h0,        -1, 32'h0, 1, 32'h44));
    tbl.push_back(mk(0, 1, 1, 32'hC0,  32'h6,    3, 32'h0,        -1, 32'h0, 1, 32'h1));
    tbl.push_back(mk(1, 0, 1, 32'hD0,  32'h0,    1, 32'h66,       -1, 32'h0, 1, 32'h66));
    tbl.push_back(mk(0, 1, 1, 32'hD4,  32'h8,    1, 32'h0,        -1, 32'h0, !ATOMIC, sc_res));
    foreach (tbl[i]) begin
      run_txn(tbl[i].ren, tbl[i].wen, tbl[i].atm, tbl[i].addr, tbl[i].store, tbl[i].k,
              tbl[i].ldv, tbl[i].snp_at, tbl[i].snp_a, r);
      check_txn($sformatf("vec%0d", i), r, tbl[i].e_nren, tbl[i].e_nwen, tbl[i].e_lat,
                tbl[i].e_ld, tbl[i].addr, tbl[i].store);
    end

    // Flush holds a pending load back: no issue, no stall; afterwards it runs normally.
    req_valid = 1'b1; req_ren = 1'b1; req_addr = 32'h180; flush = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("flush", "dmemREN", 32'(dmemREN), 32'd0);
      chk("flush", "mem_stall", 32'(mem_stall), 32'd0);
      @(posedge CLK); #1;
    end
    flush = 1'b0;
    run_txn(1, 0, 0, 32'h180, 32'h0, 1, 32'h77, -1, 32'h0, r);
    check_txn("after_flush", r, 1, 0, 2, 32'h77, 32'h180, 32'h0);

    // Reset mid-transaction drops the request and the link.
    run_txn(1, 0, 1, 32'h80, 32'h0, 1, 32'h5A, -1, 32'h0, r);
    check_txn("ll_pre_rst", r, 1, 0, 2, 32'h5A, 32'h80, 32'h0);
    req_valid = 1'b1; req_ren = 1'b1; req_addr = 32'h140;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_mid", "ren_before", 32'(dmemREN), 32'd1);
    RST = 1'b1; req_valid = 1'b0; req_ren = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid", "dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_mid", "mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_mid", "load_data", load_data, 32'd0);
    @(posedge CLK); #1;
    run_txn(0, 1, 1, 32'h80, 32'h9, 1, 32'h0, -1, 32'h0, r);
    check_txn("sc_post_rst", r, 0, ATOMIC ? 0 : 1, ATOMIC ? 1 : 2, sc_res, 32'h80, 32'h9);

    // Random transactions against a transaction-level model of the link and result word.
    m_lv = 1'b0; m_lw = '0; m_ld = sc_res;
    for (int i = 0; i < 150; i++) begin
      logic        ren, wen, atm, iss, is_sc;
      logic [31:0] addr, store, ldv, snp_a, e_ld;
      int          k, snp_at, lat, sel;
      ren   = 1'($urandom_range(0, 1));
      wen   = ren ? 1'($urandom_range(0, 1)) : 1'b1;
      atm   = 1'($urandom_range(0, 1));
      addr  = 32'h80 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      snp_a = 32'h80 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      store = $urandom;
      ldv   = $urandom;
      k     = int'($urandom_range(1, 3));
      sel   = int'($urandom_range(0, 3));
      snp_at = (sel < 2) ? -1 : ((sel == 2) ? 0 : k);

      if (ATOMIC && snp_at == 0 && m_lv && snp_a[31:2] == m_lw) m_lv = 1'b0;
      is_sc = !ren && atm;
      iss   = 1'b1;
      e_ld  = m_ld;
      if (ren) begin
        e_ld = ldv;
      end else if (is_sc) begin
        if (ATOMIC && !(m_lv && m_lw == addr[31:2])) begin
          iss = 1'b0; e_ld = 32'd0;
        end else begin
          e_ld = 32'd1;
        end
      end
      lat = iss ? k + 1 : 1;
      if (ATOMIC) begin
        if (ren && atm) begin
          m_lv = 1'b1; m_lw = addr[31:2];
        end else if (is_sc && iss) begin
          m_lv = 1'b0;
        end
        if (snp_at > 0 && snp_at <= lat && m_lv && snp_a[31:2] == m_lw) m_lv = 1'b0;
      end
      m_ld = e_ld;

      run_txn(ren, wen, atm, addr, store, k, ldv, snp_at, snp_a, r);
      check_txn($sformatf("rnd%0d", i), r, (iss && ren) ? k : 0, (iss && !ren) ? k : 0,
                lat, e_ld, addr, store);
    end

    // Halt is sticky: later requests neither issue nor stall.
    req_valid = 1'b1; req_halt = 1'b1;
    @(negedge CLK);
    chk("halt", "halt_before", 32'(halt_out), 32'd0);
    @(posedge CLK); #1;
    req_halt = 1'b0; req_ren = 1'b1; req_addr = 32'h100;
    repeat (4) begin
      @(negedge CLK);
      chk("halt", "halt_out", 32'(halt_out), 32'd1);
      chk("halt", "dmemREN", 32'(dmemREN), 32'd0);
      chk("halt", "mem_stall", 32'(mem_stall), 32'd0);
      @(posedge CLK); #1;
    end
    req_valid = 1'b0; req_ren = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
